// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage core.
// Resolves divider, redirect, refill, load-use and fetch-wait requests
// into PC/if_id/id_ex hold and flush controls, drives the PC redirect,
// and counts stalled cycles in a saturating performance counter.
module pipe_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FETCH_LAT    = 1,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              div_busy_i,
  input  logic              ibus_ready_i,
  output logic              hold_pc_o,
  output logic              pc_set_o,
  output logic [ADDR_W-1:0] pc_set_addr_o,
  output logic              hold_if_id_o,
  output logic              flush_if_id_o,
  output logic              hold_id_ex_o,
  output logic              flush_id_ex_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REDIR   = 2'd1,
    LDSTALL = 2'd2
  } state_e;

  localparam logic [2:0] FETCH_CNT  = 3'(FETCH_LAT);
  localparam logic [2:0] BUBBLE_CNT = 3'(LOAD_BUBBLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic              hold_pc, pc_set, hold_if_id, flush_if_id, hold_id_ex, flush_id_ex;
  logic [ADDR_W-1:0] pc_set_addr;

  // Priority resolution: outputs and next state from current state and requests.
  // Reset gating is applied last so every control output reads 0 while rst_i is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_pc     = 1'b0;
    pc_set      = 1'b0;
    pc_set_addr = '0;
    hold_if_id  = 1'b0;
    flush_if_id = 1'b0;
    hold_id_ex  = 1'b0;
    flush_id_ex = 1'b0;

    if (div_busy_i) begin
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
      hold_id_ex = 1'b1;
    end else if (jump_req_i) begin
      pc_set      = 1'b1;
      pc_set_addr = jump_addr_i;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = REDIR;
      cnt_d       = FETCH_CNT;
    end else begin
      case (state_q)
        REDIR: begin
          flush_if_id = 1'b1;
          if (ibus_ready_i) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_d == 3'd0) state_d = RUN;
          end
        end
        LDSTALL: begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_d == 3'd0) state_d = RUN;
        end
        default: begin
          if (load_use_i) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = LDSTALL;
              cnt_d   = BUBBLE_CNT;
            end
          end else if (!ibus_ready_i) begin
            hold_pc     = 1'b1;
            flush_if_id = 1'b1;
          end
        end
      endcase
    end

    if (!rst_i) begin
      hold_pc     = 1'b0;
      pc_set      = 1'b0;
      pc_set_addr = '0;
      hold_if_id  = 1'b0;
      flush_if_id = 1'b0;
      hold_id_ex  = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_pc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State, shared bubble/refill counter and performance counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hold_pc_o     = hold_pc;
  assign pc_set_o      = pc_set;
  assign pc_set_addr_o = pc_set_addr;
  assign hold_if_id_o  = hold_if_id;
  assign flush_if_id_o = flush_if_id;
  assign hold_id_ex_o  = hold_id_ex;
  assign flush_id_ex_o = flush_id_ex;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: two parameterisations driven by shared inputs,
// each compared every cycle against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jaddr = '0;
  logic        lu = 1'b0;
  logic        div = 1'b0;
  logic        rdy = 1'b1;

  always #5 clk = ~clk;

  // Instance 0: FETCH_LAT=1, LOAD_BUBBLES=2, CNT_W=8
  logic        a_hpc, a_set, a_hif, a_fif, a_hex, a_fex;
  logic [31:0] a_addr;
  logic [7:0]  a_cnt;
  // Instance 1: FETCH_LAT=2, LOAD_BUBBLES=3, CNT_W=4
  logic        b_hpc, b_set, b_hif, b_fif, b_hex, b_fex;
  logic [31:0] b_addr;
  logic [3:0]  b_cnt;

  pipe_ctrl #(.ADDR_W(32), .FETCH_LAT(1), .LOAD_BUBBLES(2), .CNT_W(8)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .jump_req_i(jump), .jump_addr_i(jaddr),
    .load_use_i(lu), .div_busy_i(div), .ibus_ready_i(rdy),
    .hold_pc_o(a_hpc), .pc_set_o(a_set), .pc_set_addr_o(a_addr),
    .hold_if_id_o(a_hif), .flush_if_id_o(a_fif), .hold_id_ex_o(a_hex),
    .flush_id_ex_o(a_fex), .stall_cnt_o(a_cnt));

  pipe_ctrl #(.ADDR_W(32), .FETCH_LAT(2), .LOAD_BUBBLES(3), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .jump_req_i(jump), .jump_addr_i(jaddr),
    .load_use_i(lu), .div_busy_i(div), .ibus_ready_i(rdy),
    .hold_pc_o(b_hpc), .pc_set_o(b_set), .pc_set_addr_o(b_addr),
    .hold_if_id_o(b_hif), .flush_if_id_o(b_fif), .hold_id_ex_o(b_hex),
    .flush_id_ex_o(b_fex), .stall_cnt_o(b_cnt));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state per instance: refill cycles still owed, extra bubbles still owed.
  int     FL[2]    = '{1, 2};
  int     LB[2]    = '{2, 3};
  longint MAXC[2]  = '{255, 15};
  int     refill[2];
  int     bub[2];
  longint stalls[2];
  logic   exp_hold[2];

  // Packing: {hold_pc, pc_set, addr[31:0], hold_if_id, flush_if_id, hold_id_ex, flush_id_ex}
  function automatic logic [37:0] pack(logic hpc, logic set, logic [31:0] ad,
                                       logic hif, logic fif, logic hex, logic fex);
    return {hpc, set, ad, hif, fif, hex, fex};
  endfunction

  function automatic logic [37:0] obs_out(int k);
    if (k == 0) return pack(a_hpc, a_set, a_addr, a_hif, a_fif, a_hex, a_fex);
    return pack(b_hpc, b_set, b_addr, b_hif, b_fif, b_hex, b_fex);
  endfunction

  function automatic longint obs_cnt(int k);
    if (k == 0) return longint'(a_cnt);
    return longint'(b_cnt);
  endfunction

  function automatic logic [37:0] exp_out(int k);
    if (!rst_n)            return '0;
    if (div)               return pack(1, 0, 32'h0, 1, 0, 1, 0);
    if (jump)              return pack(0, 1, jaddr, 0, 1, 0, 1);
    if (refill[k] > 0)     return pack(0, 0, 32'h0, 0, 1, 0, 0);
    if (bub[k] > 0 || lu)  return pack(1, 0, 32'h0, 1, 0, 0, 1);
    if (!rdy)              return pack(1, 0, 32'h0, 0, 1, 0, 0);
    return '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      refill[k] = 0;
      bub[k]    = 0;
      stalls[k] = 0;
    end
  endtask

  task automatic model_edge(int k, logic held);
    if (!rst_n) return;
    if (held && stalls[k] < MAXC[k]) stalls[k]++;
    if (div) return;
    if (jump) begin
      refill[k] = FL[k];
      bub[k]    = 0;
    end else if (refill[k] > 0) begin
      if (rdy) refill[k]--;
    end else if (bub[k] > 0) begin
      bub[k]--;
    end else if (lu) begin
      bub[k] = LB[k] - 1;
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    for (int k = 0; k < 2; k++) begin
      logic [37:0] e;
      e = exp_out(k);
      exp_hold[k] = e[37];
      check($sformatf("%s.outs%0d", tag, k), 64'(obs_out(k)), 64'(e));
      check($sformatf("%s.stall%0d", tag, k), 64'(obs_cnt(k)), 64'(stalls[k]));
    end
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(string tag, logic d, logic j, logic [31:0] a, logic l, logic r);
    div = d; jump = j; jaddr = a; lu = l; rdy = r;
    @(negedge clk);
    compare_all(tag);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, exp_hold[k]);
    #1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 32'h0, 0, 1);

    // Single-cycle redirect and refill.
    step("jmp0", 0, 1, 32'h0000_0100, 0, 1);
    step("jmp1", 0, 0, 32'h0, 0, 1);
    step("jmp2", 0, 0, 32'h0, 0, 1);
    step("jmp3", 0, 0, 32'h0, 0, 1);

    // Load-use hazard.
    step("lu0", 0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++) step("lu", 0, 0, 32'h0, 0, 1);

    // Divider busy for 5 cycles, jump in cycle 2 ignored.
    for (int i = 0; i < 5; i++) step("div", 1, (i == 2), 32'hDEAD_BEE0, 0, 1);
    step("div_after", 0, 0, 32'h0, 0, 1);

    // Refill stretched by instruction-bus wait states.
    step("rw_jmp", 0, 1, 32'h0000_0040, 0, 1);
    for (int i = 0; i < 3; i++) step("rw_wait", 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) step("rw_go", 0, 0, 32'h0, 0, 1);

    // Redirect on the second load-use bubble aborts the stall.
    step("ab_lu", 0, 0, 32'h0, 1, 1);
    step("ab_st", 0, 0, 32'h0, 0, 1);
    step("ab_jmp", 0, 1, 32'h0000_0200, 0, 1);
    for (int i = 0; i < 4; i++) step("ab_ref", 0, 0, 32'h0, 1, 1);
    step("ab_idle", 0, 0, 32'h0, 0, 1);

    // Asynchronous reset in the middle of a load-use stall.
    step("rs_lu", 0, 0, 32'h0, 1, 1);
    lu = 1'b1; rdy = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    @(posedge clk);
    #1 lu = 1'b0; rdy = 1'b1;
    compare_all("rst_held");
    rst_n = 1'b1;
    step("rst_run", 0, 0, 32'h0, 0, 1);
    step("rst_run2", 0, 0, 32'h0, 0, 1);

    // Drive the narrow counter into saturation.
    for (int i = 0; i < 20; i++) step("sat", 1, 0, 32'h0, 0, 1);
    n_checks++;
    assert (b_cnt === 4'd15) else begin
      n_fail++;
      $error("FAIL sat_hold observed=%0d expected=15", b_cnt);
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic d, j, l, r;
      d = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 4) != 0);
      step("rand", d, j, $urandom(), l, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. Takes hazard and redirect requests from ID, EX, the multi-cycle divider and the instruction bus, resolves priority, and drives hold/flush into the PC register, if_id and id_ex. It also drives the PC redirect. The FSM covers the redirect refill window and multi-cycle load-use bubbles, and the block keeps a stall-cycle performance counter.

Parameters:
ADDR_W, 32, width of instruction address (matches InstAddrBus)
FETCH_LAT, 1, cycles after a redirect before fetched data is valid (1..7)
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 32, width of the stall performance counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-low
jump_req_i  in  1  EX requests a redirect (branch taken / jal / jalr)
jump_addr_i  in  ADDR_W  redirect target
load_use_i  in  1  ID instruction needs the rd of the load currently in EX
div_busy_i  in  1  multi-cycle divider in EX is busy
ibus_ready_i  in  1  instruction bus returned valid data this cycle
hold_pc_o  out  1  PC keeps its value
pc_set_o  out  1  PC loads pc_set_addr_o next edge
pc_set_addr_o  out  ADDR_W  redirect target
hold_if_id_o  out  1  if_id keeps its contents
flush_if_id_o  out  1  if_id loads ZeroInst/ZeroInstAddr
hold_id_ex_o  out  1  id_ex keeps its contents
flush_id_ex_o  out  1  id_ex loads a bubble
stall_cnt_o  out  CNT_W  count of cycles with hold_pc_o=1, saturating

Behaviour:
- States: RUN, REDIR, LDSTALL. A 3-bit counter cnt is shared by REDIR and LDSTALL.
- Outputs are combinational from state and inputs. With rst_i=0, state=RUN, cnt=0 and stall_cnt_o=0 asynchronously. All control outputs are 0 and pc_set_addr_o is 0 while rst_i=0.
- Per-cycle priority, highest first: div_busy, jump, REDIR/LDSTALL state, load_use, fetch wait.
- div_busy_i=1 (any state):
  - hold_pc_o, hold_if_id_o and hold_id_ex_o are 1; no flush.
  - jump_req_i and load_use_i are ignored.
  - state and cnt are frozen.
- jump_req_i=1 with div_busy_i=0 (any state):
  - pc_set_o=1, pc_set_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, hold_pc_o=0.
  - Next state is REDIR with cnt=FETCH_LAT. A jump already in REDIR restarts cnt. A jump in LDSTALL aborts the stall.
- REDIR with no jump:
  - flush_if_id_o=1, all else 0.
  - cnt decrements only on cycles with ibus_ready_i=1; leaves for RUN on the cycle cnt reaches 0.
  - load_use_i is ignored.
- RUN with load_use_i=1:
  - hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1.
  - If LOAD_BUBBLES>1, next state is LDSTALL with cnt=LOAD_BUBBLES-1.
- LDSTALL:
  - Same outputs as the RUN load-use case; cnt decrements every cycle.
  - Goes to RUN when cnt reaches 0. load_use_i is ignored while in LDSTALL.
- RUN with ibus_ready_i=0 and no higher event: hold_pc_o=1, flush_if_id_o=1 (fetch bubble).
- RUN with nothing pending: all outputs 0.
- hold and flush of the same register are never both 1. pc_set_o=1 implies hold_pc_o=0.
- stall_cnt_o increments by 1 on each clk edge where hold_pc_o=1 and saturates at all-ones.
- Latency:
  - Redirect takes effect at the next edge.
  - With FETCH_LAT=1, the first target instruction enters if_id 2 edges after the jump cycle.

Test Plan:
- Release rst_i at cycle 0, all inputs 0, ibus_ready_i=1 -> all control outputs 0, stall_cnt_o=0 for 10 cycles. Assert rst_i=0 mid-LDSTALL -> outputs 0 immediately, state RUN.
- jump_req_i=1 for 1 cycle, jump_addr_i=0x0000_0100, FETCH_LAT=1 -> cycle 0: pc_set_o=1, addr=0x100, both flushes=1; cycle 1: flush_if_id_o=1 only; cycle 2: all 0.
- load_use_i=1 for 1 cycle, LOAD_BUBBLES=2 -> 2 consecutive cycles of hold_pc/hold_if_id/flush_id_ex, then RUN; stall_cnt_o increases by 2.
- div_busy_i=1 for 5 cycles with jump_req_i=1 in cycle 2 -> 5 cycles of three holds, pc_set_o stays 0, stall_cnt_o +5.
- REDIR with ibus_ready_i=0 for 3 cycles, FETCH_LAT=1 -> flush_if_id_o stays 1 for 4 cycles after the jump cycle, then RUN.
- jump_req_i=1 on the second cycle of LDSTALL, target 0x200 -> stall aborted, pc_set_o=1 with addr 0x200, REDIR entered. Force stall_cnt_o near max with CNT_W=4 -> holds at 15.
